// File: rtl/lfsr_event_source.sv
// Pseudo-random event source: 10-bit XNOR LFSR with a threshold compare that raises
// a handshaked event, followed by a tick-counted cooldown before the next event.
module lfsr_event_source #(
   parameter int unsigned COOLDOWN = 4,
   parameter logic [9:0]  SEED     = 10'h000
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       tick,
   input  logic       seed_load,
   input  logic [9:0] seed_in,
   input  logic [9:0] threshold,
   output logic [9:0] rnd,
   output logic       evt_valid,
   input  logic       evt_ack,
   output logic       busy
);

   localparam logic [3:0] LP_COOLDOWN = 4'(COOLDOWN);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PENDING = 2'd1,
      S_COOL    = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic [9:0] r_lfsr;
   logic [9:0] w_lfsr_step;
   logic       w_fire;

   // XNOR taps keep all-zero legal; all-ones is the only lock-up value.
   function automatic logic [9:0] lfsr_next(input logic [9:0] v);
      return {v[8:0], ~(v[9] ^ v[6])};
   endfunction

   assign w_lfsr_step = lfsr_next(r_lfsr);
   assign w_fire      = tick & ~seed_load & (threshold > w_lfsr_step);

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_lfsr <= SEED;
      end else if (seed_load) begin
         r_lfsr <= (seed_in == 10'h3FF) ? SEED : seed_in;
      end else if (tick) begin
         r_lfsr <= w_lfsr_step;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_fire) w_state_nxt = S_PENDING;
         end
         S_PENDING: begin
            if (evt_ack) begin
               if (LP_COOLDOWN == 4'd0) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_COOL;
                  w_cnt_nxt   = LP_COOLDOWN;
               end
            end
         end
         S_COOL: begin
            // The exit tick itself is never eligible to fire.
            if (tick) begin
               w_cnt_nxt = r_cnt - 4'd1;
               if (r_cnt <= 4'd1) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = 4'd0;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_comb begin
      rnd       = r_lfsr;
      evt_valid = (r_state == S_PENDING);
      busy      = (r_state != S_IDLE);
   end

endmodule

// File: doc/lfsr_event_source.md
Name: lfsr_event_source

Overview:
- Pseudo-random event source; the producer side of the 10-bit unsigned magnitude-compare path.
- Generates a 10-bit maximal-length LFSR sequence and raises a handshaked event whenever the unsigned threshold is strictly greater than the new random value.
- Drives computer-player actions and pipe-spawn decisions in the game logic; the consumer acknowledges each event.
- A cooldown enforces a minimum spacing, in ticks, between accepted events.

Parameters:
- COOLDOWN, default 4: number of ticks spent in COOL after an acknowledge. Range 0..15.
- SEED, default 10'h000: LFSR value applied at reset. It is also the substitute for an illegal seed.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- tick  input  1  single-cycle step enable, e.g. the frame or slow-clock pulse.
- seed_load  input  1  load seed_in into the LFSR this cycle.
- seed_in  input  10  seed value.
- threshold  input  10  unsigned; fire when threshold > new LFSR value.
- rnd  output  10  current LFSR register value.
- evt_valid  output  1  event pending; held high until acknowledged.
- evt_ack  input  1  consumer accepts the event.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (synchronous, highest priority):
  - lfsr=SEED, state=IDLE, cnt=0.
  - evt_valid=0, busy=0, rnd=SEED.
- LFSR:
  - next = {lfsr[8:0], ~(lfsr[9]^lfsr[6])}, an XNOR form of x^10+x^7+1 with period 1023.
  - The all-ones value is the lock-up state and is never reachable.
- LFSR update priority, per cycle:
  - Reset first.
  - Then seed_load: lfsr<=seed_in, or SEED if seed_in==10'h3FF.
  - Then tick: lfsr<=next.
  - Otherwise hold.
- The LFSR steps on every tick in every state; the state only gates event generation.
- seed_load never changes state, cnt or evt_valid.
- A seed_load in the same cycle as tick suppresses the step and suppresses the compare for that tick.
- Compare:
  - fire = tick & ~seed_load & (threshold > next).
  - Both operands are 10-bit unsigned. Equality does not fire.
  - threshold=0 never fires.
  - threshold=10'h3FF fires on every eligible tick, because next is never 3FF.
- State machine, all outputs registered:
  - IDLE:
    - fire -> PENDING; evt_valid=1 from the cycle after the tick edge.
    - The rnd visible in that cycle equals the value that fired.
  - PENDING:
    - evt_valid=1.
    - evt_ack -> COOL with cnt=COOLDOWN, or straight to IDLE if COOLDOWN==0; evt_valid=0 in the next cycle.
    - Ticks keep stepping the LFSR but do not create events; events are not queued.
  - COOL:
    - Each tick decrements cnt.
    - A tick with cnt==1 -> IDLE.
    - A fire cannot occur on the tick that exits COOL; the first eligible tick is the next one in IDLE.
- evt_ack outside PENDING is ignored.
- evt_ack held high continuously acknowledges each event one cycle after it appears.
- busy = (state != IDLE), registered together with the state.
- Reset mid-PENDING or mid-COOL: evt_valid drops the cycle after Reset and any pending event is discarded.
- Latency: tick edge -> evt_valid high is 1 cycle; evt_ack edge -> evt_valid low is 1 cycle.

Test Plan:
- Sequence check: Reset, then 8 ticks, threshold=0. rnd must read 001, 003, 007, 00F, 01F, 03F, 07F, 0FE. evt_valid stays 0.
- First event: Reset, threshold=10'h002, one tick -> rnd=001 and evt_valid=1 one cycle later. Hold evt_ack=0 for 5 ticks -> evt_valid stays 1, rnd keeps stepping.
- Cooldown: COOLDOWN=4, threshold=3FF, ack the first event. The next 4 ticks give no event and busy=1. The 5th tick fires.
- Equality and edge: seed_in=0FE with seed_load, then threshold=1FC and one tick -> next=1FC, no event. Repeat with threshold=1FD -> event fires.
- Illegal seed and priority: seed_load with seed_in=3FF -> rnd=SEED. seed_load with tick in the same cycle -> rnd=seed_in, no event, no step.
- Reset mid-operation: assert Reset while PENDING -> next cycle evt_valid=0, busy=0, rnd=SEED. A later evt_ack causes no change.
